alu_scan_display: RTL and testbench

- Parametrised successor of the lab single-cycle ALU/seven-segment demo block.
- Registers operands on a load strobe and computes a WIDTH-bit result with one-cycle latency.
- Adds shifts, XOR/NOR, signed and unsigned compare, plus zero and overflow flags.
- Time-multiplexes the registered result onto a DIGITS-digit common-anode seven-segment bank, with optional leading-zero blanking.

---
 rtl/alu_scan_display.sv | 118 +++++++++++
 tb/tb_alu_scan_display.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_scan_display.sv
// alu_scan_display: registered ALU with one-cycle latency driving a multiplexed
// common-anode seven-segment bank with optional leading-zero blanking.
module alu_scan_display #(
    parameter int          WIDTH    = 32,
    parameter int          DIGITS   = 8,
    parameter logic [31:0] SCAN_DIV = 32'h20000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              ovf,
    output logic              valid,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);
    localparam int SW = $clog2(WIDTH);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int DW = DIGITS * 4;
    localparam logic [6:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [WIDTH-1:0]  a_q, b_q, res_q, res_d;
    logic [3:0]        op_q;
    logic              pend_q, valid_q, zero_q, ovf_q, ovf_d, on_q, tick;
    logic [31:0]       div_q;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q;
    logic [SW-1:0]     sh;
    logic [DW-1:0]     ext, upper;

    assign sh = b_q[SW-1:0];

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op_q)
            4'd0: begin
                res_d = a_q + b_q;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd1: begin
                res_d = a_q - b_q;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd2:  res_d = a_q & b_q;
            4'd3:  res_d = a_q | b_q;
            4'd4:  res_d = ~a_q;
            4'd5:  res_d[0] = $signed(a_q) < $signed(b_q);
            4'd6:  res_d[0] = a_q < b_q;
            4'd7:  res_d = a_q ^ b_q;
            4'd8:  res_d = ~(a_q | b_q);
            4'd9:  res_d = a_q << sh;
            4'd10: res_d = a_q >> sh;
            4'd11: res_d = $signed(a_q) >>> sh;
            default: res_d = '0;
        endcase
    end

    assign tick  = div_q == SCAN_DIV - 32'd1;
    // The first tick after reset lights digit 0 rather than advancing past it.
    assign idx_d = !on_q ? '0 : (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            pend_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            on_q    <= 1'b0;
            an_q    <= '1;
        end else begin
            pend_q  <= load;
            valid_q <= pend_q;
            if (load) begin
                a_q  <= a_in;
                b_q  <= b_in;
                op_q <= op;
            end
            if (pend_q) begin
                res_q  <= res_d;
                zero_q <= res_d == '0;
                ovf_q  <= ovf_d;
            end
            div_q <= tick ? '0 : div_q + 32'd1;
            if (tick) begin
                on_q  <= 1'b1;
                idx_q <= idx_d;
                an_q  <= ~(DIGITS'(1) << idx_d);
            end
        end
    end

    assign ext   = DW'(res_q);
    assign upper = ext >> {idx_q, 2'b00};
    assign seg   = (!on_q || (BLANK_LZ && idx_q != '0 && upper == '0)) ? 7'h7F : FONT[upper[3:0]];

    assign result = res_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign valid  = valid_q;
    assign an     = an_q;
endmodule

// File: tb/tb_alu_scan_display.sv
// tb_alu_scan_display: directed checks of ALU ops, pipelining, digit scan, blanking and async reset
module tb_alu_scan_display;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [31:0] result, result_n;
  logic zero, ovf, valid, zero_n, ovf_n, valid_n;
  logic [7:0] an, an_n;
  logic [6:0] seg, seg_n;
  int errors = 0, checks = 0;
  alu_scan_display #(.WIDTH(32), .DIGITS(8), .SCAN_DIV(32'd4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .op(op), .a_in(a_in), .b_in(b_in),
    .result(result), .zero(zero), .ovf(ovf), .valid(valid), .an(an), .seg(seg));
  alu_scan_display #(.WIDTH(32), .DIGITS(8), .SCAN_DIV(32'd4), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst(rst), .load(load), .op(op), .a_in(a_in), .b_in(b_in),
    .result(result_n), .zero(zero_n), .ovf(ovf_n), .valid(valid_n), .an(an_n), .seg(seg_n));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    load = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic alu(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic z, input logic v);
    issue(o, a, b);
    chk({tag, "_pre_valid"}, valid, 1'b0);
    @(negedge clk);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_ovf"}, ovf, v);
    chk({tag, "_valid"}, valid, 1'b1);
    @(negedge clk);
    chk({tag, "_valid_drop"}, valid, 1'b0);
  endtask
  logic [7:0] an_exp [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [6:0] seg_exp [9] = '{7'b0000110, 7'b0001000, 7'b1001111, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0000110};
  logic [6:0] segn_exp [9] = '{7'b0000110, 7'b0001000, 7'b1001111, 7'b0000001, 7'b0000001,
                               7'b0000001, 7'b0000001, 7'b0000001, 7'b0000110};
  initial begin
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    rst = 1'b0;
    @(negedge clk);
    chk("pre_tick_an", an, 8'hFF);
    chk("pre_tick_seg", seg, 7'h7F);
    alu("add",      4'd0,  32'h0000_0001, 32'h0000_00FF, 32'h0000_0100, 1'b0, 1'b0);
    alu("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    alu("sub_ovf",  4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    alu("sub_zero", 4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
    alu("and",      4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
    alu("or",       4'd3,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1'b0);
    alu("not",      4'd4,  32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b0);
    alu("slt",      4'd5,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    alu("sltu",     4'd6,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    alu("nor",      4'd8,  32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0, 1'b0, 1'b0);
    alu("shl",      4'd9,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0);
    alu("shr",      4'd10, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0);
    alu("sra",      4'd11, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0);
    alu("op12",     4'd12, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b0);
    load = 1'b1; op = 4'd0; a_in = 32'd1; b_in = 32'd1;
    @(negedge clk);
    op = 4'd1; a_in = 32'd3; b_in = 32'd1;
    @(negedge clk);
    chk("pipe0_valid", valid, 1'b1);
    chk("pipe0_result", result, 32'd2);
    op = 4'd7; a_in = 32'hF; b_in = 32'hF;
    @(negedge clk);
    load = 1'b0;
    chk("pipe1_valid", valid, 1'b1);
    chk("pipe1_result", result, 32'd2);
    @(negedge clk);
    chk("pipe2_valid", valid, 1'b1);
    chk("pipe2_result", result, 32'd0);
    chk("pipe2_zero", zero, 1'b1);
    @(negedge clk);
    chk("pipe_end_valid", valid, 1'b0);
    issue(4'd0, 32'h0000_01A3, 32'h0);
    @(negedge clk);
    chk("scan_result", result, 32'h1A3);
    for (int i = 0; i < 20 && an == 8'hFE; i++) @(negedge clk);
    for (int i = 0; i < 20 && an != 8'hFE; i++) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      checks += 3;
      if (an !== an_exp[k]) begin
        errors++;
        $error("FAIL scan_an obs=%0h exp=%0h", an, an_exp[k]);
      end
      if (seg !== seg_exp[k]) begin
        errors++;
        $error("FAIL scan_seg obs=%0h exp=%0h", seg, seg_exp[k]);
      end
      if (seg_n !== segn_exp[k]) begin
        errors++;
        $error("FAIL scan_seg_noblank obs=%0h exp=%0h", seg_n, segn_exp[k]);
      end
      repeat (4) @(negedge clk);
    end
    load = 1'b1; op = 4'd0; a_in = 32'd5; b_in = 32'd6;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_zero", zero, 1'b1);
    chk("arst_an", an, 8'hFF);
    chk("arst_seg", seg, 7'h7F);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", valid, 1'b0);
      chk("post_rst_result", result, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
